// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    ERROR = 1'b1
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          ILEN             = 4;

endpackage

// File: rtl/fetch_unit_pc_target.sv
// rtl/fetch_unit_pc_target.sv - next-PC selection (sequential, branch, JALR) and alignment check
module pc_target
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic [ADDRESS_WIDTH-1:0] i_pc,
  input  logic                     i_br_taken,
  input  logic                     i_jalr_taken,
  input  logic [DATA_WIDTH-1:0]    i_imm,
  input  logic [DATA_WIDTH-1:0]    i_rd1,
  output logic [ADDRESS_WIDTH-1:0] o_next_pc,
  output logic                     o_misaligned
);

  logic [ADDRESS_WIDTH-1:0] w_imm;
  logic [ADDRESS_WIDTH-1:0] w_rs1;
  logic [ADDRESS_WIDTH-1:0] w_jalr_target;
  logic [ADDRESS_WIDTH-1:0] w_br_target;
  logic [ADDRESS_WIDTH-1:0] w_seq_target;

  assign w_imm         = ADDRESS_WIDTH'(i_imm);
  assign w_rs1         = ADDRESS_WIDTH'(i_rd1);
  assign w_jalr_target = (w_rs1 + w_imm) & ~ADDRESS_WIDTH'(1);
  assign w_br_target   = i_pc + w_imm;
  assign w_seq_target  = i_pc + ADDRESS_WIDTH'(ILEN);

  // JALR wins over a simultaneous branch indication
  assign o_next_pc = i_jalr_taken ? w_jalr_target :
                     i_br_taken   ? w_br_target   : w_seq_target;

  assign o_misaligned = (i_jalr_taken | i_br_taken) & (o_next_pc[1:0] != 2'b00);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, single-outstanding imem fetch and one-entry instruction buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     fetch_en,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_rvalid,
  input  logic [DATA_WIDTH-1:0]    imem_rdata,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [DATA_WIDTH-1:0]    instr,
  output logic [ADDRESS_WIDTH-1:0] pc_out,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  input  logic                     br_taken,
  input  logic                     jalr_taken,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  input  logic [DATA_WIDTH-1:0]    rd1,
  output logic                     fetch_err
);

  fetch_state_e             r_state;
  fetch_state_e             w_state_next;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0] r_req_pc;
  logic                     r_outstanding;
  logic                     r_buf_valid;
  logic [DATA_WIDTH-1:0]    r_instr;
  logic [ADDRESS_WIDTH-1:0] r_pc_out;

  logic                     w_consume;
  logic                     w_issue;
  logic                     w_accept;
  logic [ADDRESS_WIDTH-1:0] w_next_pc;
  logic                     w_misaligned;

  pc_target #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_pc_target (
    .i_pc         (r_pc_out),
    .i_br_taken   (br_taken),
    .i_jalr_taken (jalr_taken),
    .i_imm        (ImmOp),
    .i_rd1        (rd1),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Issue only when the buffer is empty or being drained, so buffer and request never both occupy
  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    imem_addr    = r_fetch_pc;
    if (r_state == RUN) begin
      w_consume = r_buf_valid & instr_ready;
      w_accept  = imem_rvalid & r_outstanding;
      if (w_consume) begin
        imem_addr = w_next_pc;
      end
      w_issue = fetch_en & ~r_outstanding & (~r_buf_valid | w_consume)
              & ~(w_consume & w_misaligned);
      if (w_consume & w_misaligned) begin
        w_state_next = ERROR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= '0;
      r_outstanding <= 1'b0;
      r_buf_valid   <= 1'b0;
      r_instr       <= '0;
      r_pc_out      <= '0;
    end else begin
      if (w_issue) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= imem_addr;
      end
      if (w_consume) begin
        r_buf_valid <= 1'b0;
        r_fetch_pc  <= w_next_pc;
      end
      if (w_accept) begin
        r_outstanding <= 1'b0;
        r_buf_valid   <= 1'b1;
        r_instr       <= imem_rdata;
        r_pc_out      <= r_req_pc;
      end
    end
  end

  assign imem_req    = w_issue;
  assign instr_valid = r_buf_valid & (r_state == RUN);
  assign instr       = r_instr;
  assign pc_out      = r_pc_out;
  assign pc_plus4    = r_pc_out + ADDRESS_WIDTH'(ILEN);
  assign fetch_err   = (r_state == ERROR);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory model
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        br_taken;
  logic        jalr_taken;
  logic [31:0] ImmOp;
  logic [31:0] rd1;
  logic        fetch_err;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          req_count = 0;
  int          mem_lat = 1;
  logic        m_pend = 1'b0;
  logic [31:0] m_addr = '0;
  int          m_cnt = 0;
  logic [31:0] exp_addr_q[$];
  exp_t        exp_c_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .br_taken    (br_taken),
    .jalr_taken  (jalr_taken),
    .ImmOp       (ImmOp),
    .rd1         (rd1),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int max);
    int k = 0;
    @(negedge clk);
    while (instr_valid !== 1'b1 && k < max) begin
      k++;
      @(negedge clk);
    end
    if (instr_valid !== 1'b1) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: instr_valid not seen within %0d cycles", name, max);
    end
  endtask

  task automatic push_c(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = 32'h1300_0000 | pc;
    exp_c_q.push_back(e);
  endtask

  // Memory: one request in flight, word returned is 0x1300_0000 | address
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'h1300_0000 | m_addr;
          m_pend      = 1'b0;
        end
      end
      @(negedge clk);
      if (imem_req === 1'b1 && !m_pend) begin
        m_pend = 1'b1;
        m_addr = imem_addr;
        m_cnt  = mem_lat;
      end
    end
  end

  // Monitor: requests and consumed instructions are matched in order against the queues
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        req_count++;
        if (exp_addr_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_req: got addr 0x%08h required no request", imem_addr);
        end else begin
          check("req_addr", imem_addr, exp_addr_q.pop_front());
        end
      end
      if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
        if (exp_c_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_consume: got pc 0x%08h required none", pc_out);
        end else begin
          e = exp_c_q.pop_front();
          check("consume_pc", pc_out, e.pc);
          check("consume_instr", instr, e.ins);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int rc;
    rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
    br_taken = 1'b0; jalr_taken = 1'b0; ImmOp = '0; rd1 = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_fetch_err", 32'(fetch_err), 32'd0);

    tick();
    rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1; mem_lat = 1;
    exp_addr_q.push_back(32'h00); exp_addr_q.push_back(32'h04);
    exp_addr_q.push_back(32'h08); exp_addr_q.push_back(32'h0C);
    exp_addr_q.push_back(32'h10); exp_addr_q.push_back(32'h08);
    push_c(32'h00); push_c(32'h04); push_c(32'h08);
    push_c(32'h0C); push_c(32'h10); push_c(32'h08);
    for (int i = 0; i <= 12; i++) begin
      if (i > 0) tick();
      if (i == 10) begin br_taken = 1'b1; ImmOp = 32'hFFFF_FFF8; end
      if (i == 11) begin br_taken = 1'b0; ImmOp = '0; end
      if (i == 12) begin jalr_taken = 1'b1; br_taken = 1'b1; rd1 = 32'h101; ImmOp = 32'h2; end
      @(negedge clk);
      check("valid_cadence", 32'(instr_valid), 32'(i >= 2 && i % 2 == 0));
      if (i == 0) begin
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
      end
      if (i == 10) begin
        check("br_pc_out", pc_out, 32'h10);
        check("br_addr", imem_addr, 32'h08);
        check("br_pc_plus4", pc_plus4, 32'h14);
      end
      if (i == 12) check("misaligned_no_req", 32'(imem_req), 32'd0);
    end
    tick();
    br_taken = 1'b0; jalr_taken = 1'b0; rd1 = '0; ImmOp = '0;
    repeat (5) begin
      @(negedge clk);
      check("err_fetch_err", 32'(fetch_err), 32'd1);
      check("err_instr_valid", 32'(instr_valid), 32'd0);
      check("err_imem_req", 32'(imem_req), 32'd0);
      tick();
    end

    rst_n = 1'b0; fetch_en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    jalr_taken = 1'b1; rd1 = 32'h101; ImmOp = 32'h3;
    exp_addr_q.push_back(32'h000); exp_addr_q.push_back(32'h104);
    push_c(32'h000);
    wait_valid("wait_jalr", 8);
    check("jalr_addr", imem_addr, 32'h104);
    check("jalr_req", 32'(imem_req), 32'd1);
    check("jalr_fetch_err", 32'(fetch_err), 32'd0);

    tick();
    instr_ready = 1'b0; jalr_taken = 1'b0; rd1 = '0; ImmOp = '0; mem_lat = 3;
    push_c(32'h104);
    wait_valid("wait_bp", 8);
    rc = req_count;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin tick(); @(negedge clk); end
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_pc_out", pc_out, 32'h104);
      check("bp_instr", instr, 32'h1300_0104);
    end
    check("bp_no_req", 32'(req_count - rc), 32'd0);

    tick();
    instr_ready = 1'b1;
    exp_addr_q.push_back(32'h108); exp_addr_q.push_back(32'h10C);
    push_c(32'h108);
    @(negedge clk);
    check("bp_release_addr", imem_addr, 32'h108);
    wait_valid("wait_108", 8);

    tick();
    rst_n = 1'b0; fetch_en = 1'b0;
    #1;
    check("async_instr", instr, 32'd0);
    check("async_pc_out", pc_out, 32'd0);
    check("async_valid", 32'(instr_valid), 32'd0);
    check("async_req", 32'(imem_req), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("late_rvalid_ignored", 32'(instr_valid), 32'd0);
    end
    tick();
    fetch_en = 1'b1; mem_lat = 1;
    exp_addr_q.push_back(32'h0); exp_addr_q.push_back(32'h4);
    push_c(32'h0);
    @(negedge clk);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, 32'h0);
    wait_valid("wait_refetch", 8);
    tick();
    fetch_en = 1'b0; instr_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("drain_valid", 32'(instr_valid), 32'd1);
    check("drain_pc_out", pc_out, 32'h4);
    check("drain_instr", instr, 32'h1300_0004);
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("cons_q_empty", 32'(exp_c_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
